// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the seven-segment display scanner.
package seven_segment_pkg;

  // Scanner phases: all anodes dark between digits, or one digit lit.
  typedef enum logic {
    BLANK   = 1'b0,
    DISPLAY = 1'b1
  } scan_state_t;

  // Widest digit count the anode helper supports; callers slice the result.
  localparam int MAX_DIGITS = 32;
  localparam int MAX_IDX_W  = $clog2(MAX_DIGITS);

  // One-hot anode pattern for a digit in the requested polarity. With lit=0
  // the pattern is "all inactive", which a suppressed slot relies on.
  function automatic logic [MAX_DIGITS-1:0] anode_encode(
    input logic [MAX_IDX_W-1:0] index,
    input logic                 lit,
    input bit                   active_low
  );
    logic [MAX_DIGITS-1:0] onehot;
    onehot = '0;
    if (lit) onehot[index] = 1'b1;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/seven_segment_refresh_timer.sv
// Loadable down-counter with a terminal-count flag. The scanner reloads it on
// every terminal count, so the flag behaves as a one-cycle pulse per dwell.
module seven_segment_refresh_timer #(
  parameter int               WIDTH       = 17,
  parameter logic [WIDTH-1:0] RESET_COUNT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_count,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  // Count down to zero and hold; a load restarts the dwell at load_count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    if (rst) begin
      count <= RESET_COUNT;
    end else if (load) begin
      count <= load_count;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/seven_segment_display_scanner.sv
// Time-multiplexes a DIGIT_COUNT-nibble hex value onto a shared seven-segment
// bus: one nibble plus valid flag to the hex converter, one anode at a time,
// with a blank gap between digits, frame-synchronous value updates, per-digit
// enables and leading-zero blanking.
module seven_segment_display_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGIT_COUNT      = 8,
  parameter int REFRESH_CYCLES   = 100000,
  parameter int BLANK_CYCLES     = 2000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIGIT_COUNT*4-1:0]       value_in,
  input  logic                           value_valid,
  input  logic [DIGIT_COUNT-1:0]         digit_enable,
  input  logic                           leading_zero_blank,
  output logic [3:0]                     hex,
  output logic                           hex_valid,
  output logic [DIGIT_COUNT-1:0]         anode,
  output logic [$clog2(DIGIT_COUNT)-1:0] digit_index,
  output logic                           frame_start
);

  localparam int IDX_W     = $clog2(DIGIT_COUNT);
  localparam int VAL_W     = DIGIT_COUNT * 4;
  localparam int DWELL_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);

  // The timer is loaded with dwell-1 and signals on reaching zero.
  localparam logic [CNT_W-1:0]       REFRESH_LOAD = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0]       BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]       LAST_INDEX   = IDX_W'(DIGIT_COUNT - 1);
  localparam logic [DIGIT_COUNT-1:0] ANODE_OFF    = ANODE_ACTIVE_LOW ? '1 : '0;

  scan_state_t            state;
  logic [VAL_W-1:0]       shadow;
  logic [VAL_W-1:0]       frame;
  logic [VAL_W-1:0]       frame_view;
  logic                   frame_load;
  logic                   timer_tc;
  logic [CNT_W-1:0]       timer_load_count;
  logic [3:0]             view_nibble;
  logic                   upper_zero;
  logic                   view_suppressed;
  logic [MAX_DIGITS-1:0]  view_anode_full;
  logic [DIGIT_COUNT-1:0] view_anode;

  // The timer restarts on every terminal count with the length of the phase
  // being entered. Its reset value makes the first blank after reset last
  // BLANK_CYCLES, so digit 0 lights at the usual slot offset.
  assign timer_load_count = (state == BLANK) ? REFRESH_LOAD : BLANK_LOAD;

  seven_segment_refresh_timer #(
    .WIDTH       (CNT_W),
    .RESET_COUNT (BLANK_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_tc),
    .load_count (timer_load_count),
    .terminal   (timer_tc)
  );

  // Work out what the slot being entered (or held) should show. On the frame
  // load edge the view already reflects the incoming frame, including a
  // same-cycle value_valid bypassing the shadow.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no
    // path leaves it unassigned and no latch is inferred.
    frame_load      = (state == BLANK) && timer_tc && (digit_index == '0);
    frame_view      = frame;
    view_nibble     = 4'h0;
    upper_zero      = 1'b1;
    if (frame_load) frame_view = value_valid ? value_in : shadow;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (digit_index == IDX_W'(i)) view_nibble = frame_view[i*4 +: 4];
      if ((IDX_W'(i) >= digit_index) && (frame_view[i*4 +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    view_suppressed = !digit_enable[digit_index] ||
                      (leading_zero_blank && (digit_index != '0) && upper_zero);
    view_anode_full = anode_encode(MAX_IDX_W'(digit_index), !view_suppressed, ANODE_ACTIVE_LOW);
    view_anode      = view_anode_full[DIGIT_COUNT-1:0];
  end

  // Scan FSM with registered outputs, shadow capture and frame load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      digit_index <= '0;
      shadow      <= '0;
      frame       <= '0;
      hex         <= 4'h0;
      hex_valid   <= 1'b0;
      anode       <= ANODE_OFF;
      frame_start <= 1'b0;
    end else begin
      if (value_valid) shadow <= value_in;
      frame_start <= 1'b0;
      unique case (state)
        BLANK: begin
          if (timer_tc) begin
            state     <= DISPLAY;
            hex       <= view_nibble;
            anode     <= view_anode;
            hex_valid <= !view_suppressed;
            if (frame_load) begin
              frame       <= frame_view;
              frame_start <= 1'b1;
            end
          end else begin
            anode     <= ANODE_OFF;
            hex_valid <= 1'b0;
          end
        end
        DISPLAY: begin
          if (timer_tc) begin
            state       <= BLANK;
            anode       <= ANODE_OFF;
            hex_valid   <= 1'b0;
            digit_index <= (digit_index == LAST_INDEX) ? '0 : digit_index + IDX_W'(1);
          end else begin
            // Enables and blanking are re-sampled every lit cycle.
            hex       <= view_nibble;
            anode     <= view_anode;
            hex_valid <= !view_suppressed;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/seven_segment_display_scanner.md
Name: seven_segment_display_scanner

Overview:
Time-multiplexes a multi-digit hex value onto a shared seven-segment bus. Each cycle it presents one nibble plus a valid flag to the downstream hex-to-segment converter, and drives the matching digit anode. Sits between register/debug logic that supplies the value and the hex converter that feeds the segment pins. It adds a frame-synchronous value update, an anti-ghosting blank interval, per-digit enables and leading-zero blanking.

Parameters:
DIGIT_COUNT, 8, number of digits scanned (>=2).
REFRESH_CYCLES, 100000, clock cycles each digit is lit (>=1).
BLANK_CYCLES, 2000, clock cycles all anodes are off between digits (>=1).
ANODE_ACTIVE_LOW, 1, 1 means an anode is asserted as 0; 0 means asserted as 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
value_in  input  DIGIT_COUNT*4  hex value; nibble i drives digit i (digit 0 = LS nibble)
value_valid  input  1  single-cycle strobe; captures value_in into the shadow register
digit_enable  input  DIGIT_COUNT  per-digit enable; sampled per slot
leading_zero_blank  input  1  suppress leading zero digits (digit 0 never suppressed)
hex  output  4  nibble for the current digit, to the converter's hex input
hex_valid  output  1  to the converter's hex_valid input; 1 only while a digit is lit
anode  output  DIGIT_COUNT  one-hot digit select in the configured polarity
digit_index  output  $clog2(DIGIT_COUNT)  current slot index
frame_start  output  1  one-cycle pulse on entry to DISPLAY for digit 0

Behaviour:
- Clocking: one clock `clk`. Reset `rst` is asynchronous and active-high. All outputs are registered.
- Reset values:
  - state=BLANK, dwell counter=0, digit_index=0, shadow=0, frame register=0.
  - hex=0, hex_valid=0, frame_start=0.
  - anode all inactive: all 1s if ANODE_ACTIVE_LOW, else all 0s.
- Shadow capture: when value_valid=1, shadow<=value_in at the next edge. A later strobe overwrites an earlier one. The shadow is never shown directly.
- State machine (2 states):
  - BLANK: anodes inactive, hex_valid=0. Counts BLANK_CYCLES cycles, then goes to DISPLAY for the current digit_index.
  - DISPLAY: lit for REFRESH_CYCLES cycles. Then goes to BLANK and advances digit_index.
  - digit_index wraps from DIGIT_COUNT-1 to 0.
- Frame load: on the BLANK->DISPLAY transition with digit_index=0, the frame register loads from the shadow and frame_start pulses for one cycle.
  - If value_valid is high in that same cycle, value_in bypasses the shadow and goes straight into the frame register (and also into the shadow).
  - Values change only at frame boundaries, so there is no tearing.
- Lit-slot outputs:
  - hex = frame nibble[digit_index].
  - anode = one-hot for digit_index, in the configured polarity.
  - hex_valid = 1 unless the digit is suppressed.
- Suppression: digit i is suppressed when digit_enable[i]=0, or when all of the following hold:
  - leading_zero_blank=1,
  - i>0,
  - frame nibbles i..DIGIT_COUNT-1 are all zero.
- A suppressed slot keeps its full timing, but its anode stays inactive and hex_valid=0. hex still shows the nibble.
- Slot period = REFRESH_CYCLES+BLANK_CYCLES. Frame period = DIGIT_COUNT times the slot period.
- digit_enable and leading_zero_blank are sampled each cycle. A change mid-slot takes effect on the next edge.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronously). After release, the first lit slot is digit 0 after BLANK_CYCLES cycles.

Decomposition:
- Shared package seven_segment_pkg holds:
  - typedef scan_state_t enum {BLANK, DISPLAY};
  - localparam function for the anode one-hot encoding with polarity.
- Sub-module seven_segment_refresh_timer: a loadable down-counter with a terminal-count pulse, used for both the DISPLAY and BLANK dwells.
- The hex converter is instantiated alongside this block by the parent, not inside it.

Test Plan:
Bench parameters: DIGIT_COUNT=4, REFRESH_CYCLES=4, BLANK_CYCLES=1, ANODE_ACTIVE_LOW=1.
1. Reset, no value_valid.
   -> anode=4'b1111 and hex_valid=0 during reset.
   -> First lit cycle is 1 cycle after release: anode=4'b1110, hex=0, frame_start=1.
   -> Slots repeat every 5 cycles in order 1110, 1101, 1011, 0111.
2. value_valid with value_in=16'hA5C3 mid-frame.
   -> Current frame shows old data.
   -> Next frame shows hex 3, C, 5, A on digits 0..3.
3. value_valid pulsed exactly on the frame-load cycle with 16'h1234.
   -> That frame shows 4, 3, 2, 1 (bypass path).
4. Value 16'h0050 with leading_zero_blank=1.
   -> Digits 2 and 3 have anode inactive and hex_valid=0.
   -> Digits 0 and 1 are lit with 0 and 5.
   -> Value 16'h0000 lights digit 0 only.
5. digit_enable=4'b1011.
   -> Digit 2 slot is dark for 4 cycles.
   -> Digit 3 still lights at the same slot offset as in scenario 1 (offset 15).
6. rst asserted during the digit 2 DISPLAY slot.
   -> anode=4'b1111, hex_valid=0 and digit_index=0 in the same cycle, without waiting for a clock edge.
   -> Shadow and frame read 0 after release.
